ss2_host_tx: RTL and testbench

- Host-side SimpleSerial v2 frame transmitter: the initiator end of the SS2 UART link, driving the target's rxd.
- Accepts one raw frame (cmd, scmd, len, data...) as a byte stream, computes CRC-8, COBS-encodes it and serializes it as 8N1 UART with a 0x00 delimiter.
- Used in simulation benches and host-side FPGA test harnesses to drive SS2 targets without a CPU.

---
 rtl/ss2_host_tx.sv | 201 ++++++++++++++++++++
 tb/tb_ss2_host_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ss2_host_tx
// Brief    : SimpleSerial v2 host transmitter - CRC-8, COBS framing, 8N1 UART.
// Revision : 1.0 - initial release
// ============================================================================
module ss2_host_tx #(
    parameter int pBIT_RATE = 6,
    parameter int pMAX_RAW  = 252
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       txd,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    localparam int              c_BW       = (pBIT_RATE > 1) ? $clog2(pBIT_RATE) : 1;
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(pBIT_RATE - 1);
    localparam logic [c_BW-1:0] c_BW_ONE   = c_BW'(1);
    localparam logic [7:0]      c_MAX_RAW  = 8'(pMAX_RAW);

    localparam logic [2:0] c_ST_LOAD  = 3'd0;
    localparam logic [2:0] c_ST_CRC   = 3'd1;
    localparam logic [2:0] c_ST_LINK  = 3'd2;
    localparam logic [2:0] c_ST_SEND  = 3'd3;
    localparam logic [2:0] c_ST_DELIM = 3'd4;
    localparam logic [2:0] c_ST_DROP  = 3'd5;

    logic [2:0]      r_state, w_next;
    logic            r_ready_en;
    logic [7:0]      r_cnt, r_lz, r_crc, r_end, r_idx;
    logic [3:0]      r_bit;
    logic [c_BW-1:0] r_bcnt;
    logic [7:0]      r_buf [256];

    logic            w_ready, w_accept, w_ovf_byte, w_bit_end, w_byte_end, w_txbit;
    logic [7:0]      w_idx, w_link_end, w_txbyte;
    logic [2:0]      w_sel;
    logic            w_we;
    logic [7:0]      w_waddr, w_wdata;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int k = 0; k < 8; k++)
            c = c[7] ? ((c << 1) ^ 8'h4D) : (c << 1);
        return c;
    endfunction

    assign w_ready    = r_ready_en && ((r_state == c_ST_LOAD) || (r_state == c_ST_DROP));
    assign s_ready    = w_ready;
    assign w_accept   = s_valid && w_ready;
    assign w_ovf_byte = (r_cnt == c_MAX_RAW);
    assign w_idx      = r_cnt + 8'd1;
    assign w_link_end = r_cnt + 8'd2;
    assign w_bit_end  = (r_bcnt == c_BIT_LAST);
    assign w_byte_end = w_bit_end && (r_bit == 4'd9);
    assign w_txbyte   = (r_state == c_ST_DELIM) ? 8'h00 : r_buf[r_idx];
    assign w_sel      = 3'(r_bit - 4'd1);
    // r_bit: 0 = start, 1..8 = data LSB first, 9 = stop
    assign w_txbit    = (r_bit == 4'd0) ? 1'b0 : (r_bit == 4'd9) ? 1'b1 : w_txbyte[w_sel];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_LOAD;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b1;
        done     = 1'b0;
        overflow = 1'b0;
        txd      = 1'b1;
        w_we     = 1'b0;
        w_waddr  = 8'h00;
        w_wdata  = 8'h00;
        case (r_state)
            c_ST_LOAD: begin
                busy = 1'b0;
                if (w_accept) begin
                    if (w_ovf_byte) begin
                        overflow = 1'b1;
                        w_next   = s_last ? c_ST_LOAD : c_ST_DROP;
                    end else begin
                        w_we = 1'b1;
                        if (s_data != 8'h00) begin
                            w_waddr = w_idx;
                            w_wdata = s_data;
                        end else begin
                            w_waddr = r_lz;
                            w_wdata = w_idx - r_lz;
                        end
                        if (s_last) w_next = c_ST_CRC;
                    end
                end
            end
            c_ST_CRC: begin
                w_we = 1'b1;
                if (r_crc != 8'h00) begin
                    w_waddr = w_idx;
                    w_wdata = r_crc;
                end else begin
                    w_waddr = r_lz;
                    w_wdata = w_idx - r_lz;
                end
                w_next = c_ST_LINK;
            end
            c_ST_LINK: begin
                w_we    = 1'b1;
                w_waddr = r_lz;
                w_wdata = w_link_end - r_lz;
                w_next  = c_ST_SEND;
            end
            c_ST_SEND: begin
                txd = w_txbit;
                if (w_byte_end && (r_idx == r_end - 8'd1)) w_next = c_ST_DELIM;
            end
            c_ST_DELIM: begin
                txd = w_txbit;
                if (w_byte_end) begin
                    done   = 1'b1;
                    w_next = c_ST_LOAD;
                end
            end
            c_ST_DROP: begin
                busy = 1'b0;
                if (w_accept && s_last) w_next = c_ST_LOAD;
            end
            default: w_next = c_ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) r_buf[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready_en <= 1'b0;
            r_cnt      <= 8'h00;
            r_lz       <= 8'h00;
            r_crc      <= 8'h00;
            r_end      <= 8'h00;
            r_idx      <= 8'h00;
            r_bit      <= 4'd0;
            r_bcnt     <= '0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                c_ST_LOAD: begin
                    if (w_accept) begin
                        if (w_ovf_byte) begin
                            r_cnt <= 8'h00;
                            r_lz  <= 8'h00;
                            r_crc <= 8'h00;
                        end else begin
                            r_cnt <= w_idx;
                            r_crc <= crc8_byte(r_crc, s_data);
                            if (s_data == 8'h00) r_lz <= w_idx;
                        end
                    end
                end
                c_ST_CRC: begin
                    if (r_crc == 8'h00) r_lz <= w_idx;
                end
                // Frame length is latched here so the load registers start clean next frame
                c_ST_LINK: begin
                    r_end  <= w_link_end;
                    r_cnt  <= 8'h00;
                    r_lz   <= 8'h00;
                    r_crc  <= 8'h00;
                    r_idx  <= 8'h00;
                    r_bit  <= 4'd0;
                    r_bcnt <= '0;
                end
                c_ST_SEND, c_ST_DELIM: begin
                    if (w_bit_end) begin
                        r_bcnt <= '0;
                        if (r_bit == 4'd9) begin
                            r_bit <= 4'd0;
                            r_idx <= r_idx + 8'd1;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + c_BW_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ss2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ss2_host_tx
// Brief    : Directed bench for ss2_host_tx at bit rates 6 and 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ss2_host_tx;

    localparam int c_WAIT_MAX = 20000;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] r_data   = 8'h00;
    logic       r_last   = 1'b0;
    logic       r_valid6 = 1'b0;
    logic       r_valid2 = 1'b0;

    logic w_ready6, w_txd6, w_busy6, w_done6, w_ovf6;
    logic w_ready2, w_txd2, w_busy2, w_done2, w_ovf2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] send_q [$];
    logic [7:0] exp_q  [$];
    int acc_first_cyc, done_cyc, cur_byte;
    bit mon_en = 1'b0;
    int mon_ovf, mon_ovf_at, mon_done, mon_txlow, mon_nrdy;

    ss2_host_tx #(.pBIT_RATE(6), .pMAX_RAW(252)) u_dut6 (
        .clk(clk), .reset(reset), .s_data(r_data), .s_valid(r_valid6), .s_last(r_last),
        .s_ready(w_ready6), .txd(w_txd6), .busy(w_busy6), .done(w_done6), .overflow(w_ovf6)
    );

    ss2_host_tx #(.pBIT_RATE(2), .pMAX_RAW(252)) u_dut2 (
        .clk(clk), .reset(reset), .s_data(r_data), .s_valid(r_valid2), .s_last(r_last),
        .s_ready(w_ready2), .txd(w_txd2), .busy(w_busy2), .done(w_done2), .overflow(w_ovf2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_txd(input bit sel);   return sel ? w_txd2   : w_txd6;   endfunction
    function automatic logic get_busy(input bit sel);  return sel ? w_busy2  : w_busy6;  endfunction
    function automatic logic get_ready(input bit sel); return sel ? w_ready2 : w_ready6; endfunction
    function automatic logic get_done(input bit sel);  return sel ? w_done2  : w_done6;  endfunction

    task automatic set_valid(input bit sel, input logic v);
        if (sel) r_valid2 = v;
        else     r_valid6 = v;
    endtask

    // Reference: bit-serial CRC-8 then textbook COBS over raw+CRC, plus delimiter
    task automatic build_exp();
        logic [7:0] crc;
        logic [7:0] d [$];
        logic       fb;
        int         ci;
        logic [7:0] code;
        crc = 8'h00;
        foreach (send_q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[7] ^ send_q[i][b];
                crc = {crc[6:0], 1'b0};
                if (fb) crc = crc ^ 8'h4D;
            end
        end
        d = send_q;
        d.push_back(crc);
        exp_q.delete();
        exp_q.push_back(8'h00);
        ci   = 0;
        code = 8'd1;
        foreach (d[i]) begin
            if (d[i] == 8'h00) begin
                exp_q[ci] = code;
                ci        = exp_q.size();
                exp_q.push_back(8'h00);
                code      = 8'd1;
            end else begin
                exp_q.push_back(d[i]);
                code = code + 8'd1;
            end
        end
        exp_q[ci] = code;
        exp_q.push_back(8'h00);
    endtask

    // Called at a falling edge; returns at the falling edge after the last byte is taken
    task automatic send_frame(input bit sel);
        int w;
        for (int i = 0; i < send_q.size(); i++) begin
            r_data   = send_q[i];
            r_last   = (i == send_q.size() - 1);
            cur_byte = i + 1;
            set_valid(sel, 1'b1);
            w = 0;
            while (!get_ready(sel) && w < c_WAIT_MAX) begin
                @(negedge clk);
                w++;
            end
            if (w >= c_WAIT_MAX) begin
                check_eq("send_timeout", get_ready(sel), 1'b1);
                return;
            end
            if (i == 0) acc_first_cyc = cyc;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Starts at the falling edge of cycle T+1; checks every sample of the wire frame
    task automatic rx_frame(input bit sel, input int br, input string name);
        int         total, nd, dpos, bad, bi;
        logic [9:0] fr;
        logic       cur;
        check_eq({name, "_busy_t1"}, get_busy(sel), 1'b1);
        @(negedge clk);
        check_eq({name, "_idle_t2"}, get_txd(sel), 1'b1);
        @(negedge clk);
        total = 10 * br * exp_q.size();
        nd = 0; dpos = -1; bad = 0; fr = '0;
        for (int s = 0; s < total; s++) begin
            if (s != 0) @(negedge clk);
            cur = get_txd(sel);
            bi  = (s / br) % 10;
            if (s % br == 0) fr[bi] = cur;
            else if (cur !== fr[bi]) bad++;
            if (get_done(sel) === 1'b1) begin
                nd++;
                dpos     = s;
                done_cyc = cyc;
            end
            if (s % (10 * br) == 10 * br - 1)
                check_eq($sformatf("%s_byte%0d", name, s / (10 * br)), {22'd0, fr},
                         {22'd0, 1'b1, exp_q[s / (10 * br)], 1'b0});
        end
        check_eq({name, "_bit_width"}, bad, 0);
        check_eq({name, "_done_count"}, nd, 1);
        check_eq({name, "_done_pos"}, dpos, total - 1);
        @(negedge clk);
        check_eq({name, "_busy_after"}, get_busy(sel), 1'b0);
        check_eq({name, "_ready_after"}, get_ready(sel), 1'b1);
        check_eq({name, "_txd_after"}, get_txd(sel), 1'b1);
    endtask

    task automatic clear_mon();
        mon_ovf = 0; mon_ovf_at = 0; mon_done = 0; mon_txlow = 0; mon_nrdy = 0;
    endtask

    task automatic back_to_back(input bit sel, input int br, input string name);
        send_q = '{8'h01, 8'h00, 8'h00};
        send_frame(sel);
        exp_q  = '{8'h02, 8'h01, 8'h01, 8'h02, 8'h06, 8'h00};
        send_q = '{8'h11, 8'h00, 8'h22, 8'h33};
        fork
            rx_frame(sel, br, {name, "_a"});
            send_frame(sel);
        join
        set_valid(sel, 1'b0);
        check_eq({name, "_gap"}, acc_first_cyc, done_cyc + 1);
        build_exp();
        rx_frame(sel, br, {name, "_b"});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (w_ovf6 === 1'b1) begin
                    mon_ovf++;
                    mon_ovf_at = cur_byte;
                end
                if (w_done6 === 1'b1)  mon_done++;
                if (w_txd6 !== 1'b1)   mon_txlow++;
                if (w_ready6 !== 1'b1) mon_nrdy++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear_mon();
        repeat (3) @(negedge clk);
        check_eq("rst_txd6", w_txd6, 1'b1);
        check_eq("rst_busy6", w_busy6, 1'b0);
        check_eq("rst_ready6", w_ready6, 1'b0);
        check_eq("rst_done6", w_done6, 1'b0);
        check_eq("rst_ovf6", w_ovf6, 1'b0);
        check_eq("rst_txd2", w_txd2, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("ready_before_clk", w_ready6, 1'b0);
        @(negedge clk);
        check_eq("ready_after_clk6", w_ready6, 1'b1);
        check_eq("ready_after_clk2", w_ready2, 1'b1);

        send_q = '{8'h01, 8'h00, 8'h00};
        send_frame(1'b0);
        r_valid6 = 1'b0;
        exp_q = '{8'h02, 8'h01, 8'h01, 8'h02, 8'h06, 8'h00};
        rx_frame(1'b0, 6, "f1_br6");

        send_q = '{8'h00};
        send_frame(1'b0);
        r_valid6 = 1'b0;
        exp_q = '{8'h01, 8'h01, 8'h01, 8'h00};
        rx_frame(1'b0, 6, "f0_br6");

        send_q = '{8'h01, 8'h00, 8'h00};
        send_frame(1'b1);
        r_valid2 = 1'b0;
        exp_q = '{8'h02, 8'h01, 8'h01, 8'h02, 8'h06, 8'h00};
        rx_frame(1'b1, 2, "f1_br2");

        send_q = '{8'h00};
        send_frame(1'b1);
        r_valid2 = 1'b0;
        exp_q = '{8'h01, 8'h01, 8'h01, 8'h00};
        rx_frame(1'b1, 2, "f0_br2");

        send_q.delete();
        for (int k = 0; k < 252; k++) send_q.push_back(8'((k % 255) + 1));
        build_exp();
        clear_mon();
        mon_en = 1'b1;
        send_frame(1'b0);
        r_valid6 = 1'b0;
        rx_frame(1'b0, 6, "max");
        mon_en = 1'b0;
        check_eq("max_no_ovf", mon_ovf, 0);

        send_q.delete();
        for (int k = 0; k < 260; k++) send_q.push_back(8'(k + 1));
        clear_mon();
        mon_en = 1'b1;
        send_frame(1'b0);
        r_valid6 = 1'b0;
        repeat (50) @(negedge clk);
        mon_en = 1'b0;
        check_eq("ovf_count", mon_ovf, 1);
        check_eq("ovf_byte", mon_ovf_at, 253);
        check_eq("ovf_no_done", mon_done, 0);
        check_eq("ovf_txd_low", mon_txlow, 0);
        check_eq("ovf_ready_low", mon_nrdy, 0);

        back_to_back(1'b0, 6, "b2b_br6");
        back_to_back(1'b1, 2, "b2b_br2");

        send_q = '{8'h01, 8'h00, 8'h00};
        send_frame(1'b0);
        r_valid6 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        repeat (15 * 6 + 2) @(negedge clk);
        check_eq("midbit_txd", w_txd6, 1'b0);
        check_eq("midbit_busy", w_busy6, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_eq("async_rst_txd", w_txd6, 1'b1);
        check_eq("async_rst_busy", w_busy6, 1'b0);
        check_eq("async_rst_ready", w_ready6, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", w_ready6, 1'b1);
        send_q = '{8'h01, 8'h00, 8'h00};
        send_frame(1'b0);
        r_valid6 = 1'b0;
        exp_q = '{8'h02, 8'h01, 8'h01, 8'h02, 8'h06, 8'h00};
        rx_frame(1'b0, 6, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
